imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Two-port arbiter and sequencer for the single-read-port instruction ROM. It shares the ROM between the core's instruction-fetch port and a secondary read port, which carries constant-pool loads and debug reads of the text region. Fetch has fixed priority, and the data port is protected from starvation by a wait counter. Each port sees a request/grant handshake with a registered response one cycle after grant. The block sits between the fetch stage/LSU and the ROM's `addr_i`/`dout_o`.

## Interface
- `ADDR_WIDTH`, 10, byte-address width, matches the ROM `addr_i`.
- `DATA_WIDTH`, 32, word width, matches the ROM `dout_o`.
- `MAX_WAIT`, 4, consecutive denied data-port cycles before the data port is forced a grant; legal range 1..15.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `f_req_i`  in  1  fetch request.
- `f_addr_i`  in  ADDR_WIDTH  fetch byte address.
- `f_flush_i`  in  1  discard the fetch response due next cycle (branch redirect).
- `f_gnt_o`  out  1  fetch request accepted this cycle.
- `f_rvalid_o`  out  1  fetch response valid.
- `f_rdata_o`  out  DATA_WIDTH  fetch response word.
- `f_err_o`  out  1  fetch response is for a misaligned address; qualified by `f_rvalid_o`.
- `d_req_i`  in  1  data request.
- `d_addr_i`  in  ADDR_WIDTH  data byte address.
- `d_gnt_o`  out  1  data request accepted this cycle.
- `d_rvalid_o`  out  1  data response valid.
- `d_rdata_o`  out  DATA_WIDTH  data response word.
- `d_err_o`  out  1  data response is for a misaligned address; qualified by `d_rvalid_o`.
- `mem_addr_o`  out  ADDR_WIDTH  address driven to the ROM.
- `mem_rdata_i`  in  DATA_WIDTH  ROM read data, combinational from `mem_addr_o`.

## Operation
- **Handshake:** a requester holds `req` high and `addr` stable until it sees `gnt`. A grant fires when `req & gnt` are both high at a rising edge. Dropping `req` before grant is legal and withdraws the request.
- **Arbitration** (combinational, one grant per cycle at most):
  - `force_d = d_req_i & (wait_cnt == MAX_WAIT)`.
  - `d_gnt_o = d_req_i & (~f_req_i | force_d)`.
  - `f_gnt_o = f_req_i & ~force_d`.
- **Address mux:** `mem_addr_o` is `d_addr_i` when `d_gnt_o` is high, otherwise `f_addr_i`. The idle default is the fetch address.
- **Wait counter** `wait_cnt`, width 4:
  - Increments on every cycle with `d_req_i & ~d_gnt_o`.
  - Clears to 0 on `d_gnt_o`, and also when `d_req_i` is low.
  - Saturates at `MAX_WAIT`.
- **Response capture** on a granted cycle:
  - `x_rdata_o <= mem_rdata_i`.
  - `x_err_o <= (addr[1:0] != 0)`.
  - `x_rvalid_o <= 1`.
  - The ROM access is still performed; the ROM ignores `addr[1:0]`.
- **Response retention:** with no grant, `x_rvalid_o <= 0`, and `x_rdata_o` and `x_err_o` hold their last value.
- **Flush:** if `f_flush_i` is high on a cycle, `f_rvalid_o` is forced to 0 at the next edge regardless of the fetch grant in that cycle.
  - `f_gnt_o` is unaffected.
  - The ROM slot is still consumed.
- **Pipelining:** back-to-back grants to the same port are allowed. There is no buffering beyond one response register per port, and no backpressure on responses; requesters must always accept `rvalid`.

## Timing
- **Reset** (asynchronous assert, synchronous deassert handled upstream): the following are 0 immediately and stay 0 until the first grant completes:
  - `wait_cnt`
  - `f_rvalid_o`, `d_rvalid_o`
  - `f_rdata_o`, `d_rdata_o`
  - `f_err_o`, `d_err_o`
- **Reset mid-operation:** a reset while a response is due drops that response. No response is produced after reset for a grant made before it.
- **Grant latency:** 0 cycles. `gnt` is combinational from `req` and `wait_cnt`.
- **Response latency:** exactly 1 cycle after the granting edge.
- **Throughput:** 1 grant per cycle total across both ports.
- **Starvation bound:** with `f_req_i` held high, a continuously requesting data port is granted on its `(MAX_WAIT+1)`-th cycle of request.
  - Fetch loses exactly that one cycle.
  - `wait_cnt` then returns to 0.
- **Simultaneous requests**, with `wait_cnt < MAX_WAIT`: fetch wins. Data `wait_cnt` increments.

## Test plan
- **Reset values:** assert `rst_ni=0` mid-stream with a response pending -> all outputs are 0 within the same cycle. After release, no `rvalid` appears until a new grant.
- **Fetch only:** `f_req_i=1`, `f_addr_i` = 0x000, 0x004, 0x008 on consecutive cycles -> `f_gnt_o=1` each cycle. `f_rvalid_o=1` on the following cycles with `f_rdata_o` = ROM words 0, 1, 2, and `f_err_o=0`.
- **Starvation, `MAX_WAIT=4`:** `f_req_i` and `d_req_i` both held high, `d_addr_i=0x010`:
  - `d_gnt_o` is high on exactly the 5th cycle, with `f_gnt_o=0` that cycle.
  - Next cycle `d_rvalid_o=1` and `d_rdata_o` = ROM word 4.
  - The pattern repeats every 5 cycles.
- **Misaligned access:** `d_req_i=1`, `d_addr_i=0x006`, fetch idle -> immediate grant. Next cycle `d_rvalid_o=1`, `d_err_o=1`, `d_rdata_o` = ROM word 1.
- **Flush:** fetch granted at 0x020 with `f_flush_i=1` in the same cycle -> `f_rvalid_o` stays 0 next cycle. A fetch grant at 0x024 on the following cycle with no flush -> `f_rvalid_o=1`, `f_rdata_o` = ROM word 9.
- **Request withdrawal:** `d_req_i` high for 2 denied cycles, then low for 1 -> `wait_cnt` returns to 0. A new starvation window takes a full 5 cycles.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-read-port instruction ROM between the fetch
// port (fixed priority) and a data/debug read port (starvation-protected).
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   f_req_i/f_addr_i          fetch request and byte address
//   f_flush_i                 drop the fetch response due next cycle
//   f_gnt_o                   fetch grant (combinational)
//   f_rvalid_o/f_rdata_o/f_err_o  registered fetch response
//   d_req_i/d_addr_i          data request and byte address
//   d_gnt_o                   data grant (combinational)
//   d_rvalid_o/d_rdata_o/d_err_o  registered data response
//   mem_addr_o/mem_rdata_i    ROM address out, ROM data in (combinational ROM)
module imem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  f_req_i,
   input  logic [ADDR_WIDTH-1:0] f_addr_i,
   input  logic                  f_flush_i,
   output logic                  f_gnt_o,
   output logic                  f_rvalid_o,
   output logic [DATA_WIDTH-1:0] f_rdata_o,
   output logic                  f_err_o,
   input  logic                  d_req_i,
   input  logic [ADDR_WIDTH-1:0] d_addr_i,
   output logic                  d_gnt_o,
   output logic                  d_rvalid_o,
   output logic [DATA_WIDTH-1:0] d_rdata_o,
   output logic                  d_err_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_cnt_nxt;
   logic             force_d;

   // Fixed-priority arbitration with forced data grant once the wait budget is spent
   always_comb begin
      force_d    = d_req_i & (wait_cnt == MAX_WAIT_C);
      d_gnt_o    = d_req_i & (~f_req_i | force_d);
      f_gnt_o    = f_req_i & ~force_d;
      mem_addr_o = d_gnt_o ? d_addr_i : f_addr_i;
   end

   // Count consecutive denied data cycles; withdrawal or grant restarts the window
   always_comb begin
      wait_cnt_nxt = '0;
      if (d_req_i && !d_gnt_o) begin
         if (wait_cnt != MAX_WAIT_C) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
         end else begin
            wait_cnt_nxt = wait_cnt;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Fetch response register; a flush suppresses valid but the ROM slot is spent
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         f_rvalid_o <= 1'b0;
         f_rdata_o  <= '0;
         f_err_o    <= 1'b0;
      end else begin
         f_rvalid_o <= f_gnt_o & ~f_flush_i;
         if (f_gnt_o) begin
            f_rdata_o <= mem_rdata_i;
            f_err_o   <= (f_addr_i[1:0] != 2'b00);
         end
      end
   end

   // Data response register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         d_rvalid_o <= 1'b0;
         d_rdata_o  <= '0;
         d_err_o    <= 1'b0;
      end else begin
         d_rvalid_o <= d_gnt_o;
         if (d_gnt_o) begin
            d_rdata_o <= mem_rdata_i;
            d_err_o   <= (d_addr_i[1:0] != 2'b00);
         end
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a combinational ROM model whose word k
// reads as 32'hC0DE_0000 | k.
module tb_imem_arbiter;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          f_req_i;
   logic [AW-1:0] f_addr_i;
   logic          f_flush_i;
   logic          f_gnt_o;
   logic          f_rvalid_o;
   logic [DW-1:0] f_rdata_o;
   logic          f_err_o;
   logic          d_req_i;
   logic [AW-1:0] d_addr_i;
   logic          d_gnt_o;
   logic          d_rvalid_o;
   logic [DW-1:0] d_rdata_o;
   logic          d_err_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_rdata_i;

   int errors = 0;
   int checks = 0;

   imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .f_req_i    (f_req_i),
      .f_addr_i   (f_addr_i),
      .f_flush_i  (f_flush_i),
      .f_gnt_o    (f_gnt_o),
      .f_rvalid_o (f_rvalid_o),
      .f_rdata_o  (f_rdata_o),
      .f_err_o    (f_err_o),
      .d_req_i    (d_req_i),
      .d_addr_i   (d_addr_i),
      .d_gnt_o    (d_gnt_o),
      .d_rvalid_o (d_rvalid_o),
      .d_rdata_o  (d_rdata_o),
      .d_err_o    (d_err_o),
      .mem_addr_o (mem_addr_o),
      .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // ROM model: word index is the byte address with the low two bits dropped
   assign mem_rdata_i = 32'hC0DE_0000 | 32'(mem_addr_o[AW-1:2]);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic exp_g;
      rst_ni    = 1'b0;
      f_req_i   = 1'b0;
      f_addr_i  = '0;
      f_flush_i = 1'b0;
      d_req_i   = 1'b0;
      d_addr_i  = '0;
      #12;
      chk("rst_f_rvalid", 32'(f_rvalid_o), 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid_o), 32'd0);
      chk("rst_f_rdata", f_rdata_o, 32'd0);
      chk("rst_d_rdata", d_rdata_o, 32'd0);
      chk("rst_errs", 32'({f_err_o, d_err_o}), 32'd0);
      tick();
      rst_ni = 1'b1;
      tick();
      chk("idle_no_rvalid", 32'({f_rvalid_o, d_rvalid_o}), 32'd0);

      // Fetch only, three consecutive words
      f_req_i  = 1'b1;
      f_addr_i = 10'h000;
      #1;
      chk("fo_gnt0", 32'(f_gnt_o), 32'd1);
      chk("fo_addr0", 32'(mem_addr_o), 32'h000);
      tick();
      chk("fo_rvalid0", 32'(f_rvalid_o), 32'd1);
      chk("fo_rdata0", f_rdata_o, 32'hC0DE_0000);
      chk("fo_err0", 32'(f_err_o), 32'd0);
      f_addr_i = 10'h004;
      #1;
      chk("fo_gnt1", 32'(f_gnt_o), 32'd1);
      tick();
      chk("fo_rvalid1", 32'(f_rvalid_o), 32'd1);
      chk("fo_rdata1", f_rdata_o, 32'hC0DE_0001);
      f_addr_i = 10'h008;
      #1;
      chk("fo_gnt2", 32'(f_gnt_o), 32'd1);
      tick();
      chk("fo_rvalid2", 32'(f_rvalid_o), 32'd1);
      chk("fo_rdata2", f_rdata_o, 32'hC0DE_0002);
      f_req_i = 1'b0;
      tick();
      chk("fo_rvalid_drop", 32'(f_rvalid_o), 32'd0);
      chk("fo_rdata_hold", f_rdata_o, 32'hC0DE_0002);

      // Misaligned data read with fetch idle
      d_req_i  = 1'b1;
      d_addr_i = 10'h006;
      #1;
      chk("mis_gnt", 32'(d_gnt_o), 32'd1);
      chk("mis_addr", 32'(mem_addr_o), 32'h006);
      tick();
      chk("mis_rvalid", 32'(d_rvalid_o), 32'd1);
      chk("mis_err", 32'(d_err_o), 32'd1);
      chk("mis_rdata", d_rdata_o, 32'hC0DE_0001);
      d_req_i = 1'b0;
      tick();

      // Starvation: both ports held high, data forced through every 5th cycle
      f_req_i  = 1'b1;
      f_addr_i = 10'h100;
      d_req_i  = 1'b1;
      d_addr_i = 10'h010;
      for (int c = 1; c <= 10; c++) begin
         exp_g = (c % 5 == 0);
         #1;
         chk($sformatf("stv_d_gnt_c%0d", c), 32'(d_gnt_o), 32'(exp_g));
         chk($sformatf("stv_f_gnt_c%0d", c), 32'(f_gnt_o), 32'(!exp_g));
         tick();
         chk($sformatf("stv_d_rvalid_c%0d", c), 32'(d_rvalid_o), 32'(exp_g));
         chk($sformatf("stv_f_rvalid_c%0d", c), 32'(f_rvalid_o), 32'(!exp_g));
         if (exp_g) chk($sformatf("stv_d_rdata_c%0d", c), d_rdata_o, 32'hC0DE_0004);
         else       chk($sformatf("stv_f_rdata_c%0d", c), f_rdata_o, 32'hC0DE_0040);
      end

      // Withdrawal: 2 denied cycles, 1 idle, then a full 5-cycle window again
      for (int c = 1; c <= 2; c++) begin
         #1;
         chk($sformatf("wd_pre_gnt_c%0d", c), 32'(d_gnt_o), 32'd0);
         tick();
      end
      d_req_i = 1'b0;
      tick();
      d_req_i = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         #1;
         chk($sformatf("wd_gnt_c%0d", c), 32'(d_gnt_o), 32'(c == 5));
         tick();
      end
      d_req_i = 1'b0;

      // Flush drops the response of the same-cycle grant only
      f_addr_i  = 10'h020;
      f_flush_i = 1'b1;
      #1;
      chk("fl_gnt", 32'(f_gnt_o), 32'd1);
      tick();
      chk("fl_rvalid_dropped", 32'(f_rvalid_o), 32'd0);
      f_addr_i  = 10'h024;
      f_flush_i = 1'b0;
      #1;
      chk("fl_gnt_next", 32'(f_gnt_o), 32'd1);
      tick();
      chk("fl_rvalid_next", 32'(f_rvalid_o), 32'd1);
      chk("fl_rdata_next", f_rdata_o, 32'hC0DE_0009);

      // Reset mid-stream with a response pending
      f_addr_i = 10'h00C;
      tick();
      chk("mr_rvalid_before", 32'(f_rvalid_o), 32'd1);
      chk("mr_rdata_before", f_rdata_o, 32'hC0DE_0003);
      rst_ni = 1'b0;
      #1;
      chk("mr_f_rvalid", 32'(f_rvalid_o), 32'd0);
      chk("mr_f_rdata", f_rdata_o, 32'd0);
      chk("mr_d_all", 32'({d_rvalid_o, d_err_o, f_err_o}), 32'd0);
      chk("mr_d_rdata", d_rdata_o, 32'd0);
      tick();
      f_req_i = 1'b0;
      rst_ni  = 1'b1;
      tick();
      chk("mr_no_rvalid_after", 32'({f_rvalid_o, d_rvalid_o}), 32'd0);
      chk("mr_rdata_after", f_rdata_o, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
